instr_fetch: RTL and testbench

//  Fetch stage that drives Memory_Text and feeds decode. Holds the PC, issues one read per

---
 rtl/miscv_pkg.sv | 29 ++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/miscv_pkg.sv
// Shared types and constants for the miscv fetch path.
//   XLEN / ADDR_W : instruction word and word-address widths
//   NOP_INSTR     : word driven to decode when nothing is valid
//   fetch_state_e : fetch control state
//   fetch_entry_t : one buffered {pc, instr} pair
package miscv_pkg;

    localparam int XLEN   = 16;
    localparam int ADDR_W = 16;

    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   instr;
    } fetch_entry_t;

    // Word-address increment; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs sitting between Memory_Text and decode.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : {pc, instr} entry to store
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : empty the FIFO; wins over push and pop
//   count      : number of valid entries
//   head       : oldest entry (meaningful only when count != 0)
module fetch_buffer
    import miscv_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_q [BUF_DEPTH];
    fetch_entry_t     mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap at BUF_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            // With count == BUF_DEPTH and pop, wr_q == rd_q: the slot being
            // overwritten is the head that decode is taking this cycle.
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_q];

    // The issue credit check must never let a word arrive with no room for it.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !pop && (count_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, issues one read per cycle to synchronous
// Memory_Text, tags returning words with their PC and hands (pc, instr)
// to decode over valid/ready. Handles branch redirect and halt.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_addr/we/data, imem_q : Memory_Text port (read-only use; q is 1 cycle after addr)
//   redirect_valid/pc         : taken branch/jump to a word address
//   halt_req, halted          : stop issuing; halted once no read is outstanding
//   if_valid/ready/instr/pc   : decode handshake
module instr_fetch
    import miscv_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [XLEN-1:0]   imem_data,
    input  logic [XLEN-1:0]   imem_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              redir;
    logic              pop;
    logic              push;
    logic              issue;
    logic              credit_ok;
    logic [CNT_W:0]    occ;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  buf_count;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_entry;

    fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redir),
        .count    (buf_count),
        .head     (buf_head)
    );

    always_comb begin
        // Redirects arriving during the boot cycle are dropped.
        redir      = redirect_valid && (state_q != S_BOOT);
        pop        = if_valid && if_ready;
        push       = inflight_q && !redir;
        push_entry = '{pc: inflight_pc_q, instr: imem_q};

        // Credit: entries that will still occupy the buffer after this cycle,
        // counting a head accepted now as already gone so that a two-entry
        // buffer can keep one read per cycle going while decode is draining.
        occ       = {1'b0, buf_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        credit_ok = redir || (occ < (CNT_W+1)'(BUF_DEPTH));
        issue     = (state_q == S_RUN) && !halt_req && credit_ok;

        fetch_pc      = redir ? redirect_pc : pc_q;
        pc_d          = issue ? pc_inc(fetch_pc) : fetch_pc;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc : inflight_pc_q;

        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (halt_req)  state_d = S_HALT;
            S_HALT:  if (!halt_req) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Memory_Text samples the address every cycle; a read only matters when
    // the inflight tag is set, so imem_addr can simply follow the fetch PC.
    assign imem_addr = fetch_pc;
    assign imem_we   = 1'b0;
    assign imem_data = '0;

    assign if_valid = (buf_count != '0);
    assign if_pc    = if_valid ? buf_head.pc    : '0;
    assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
    assign halted   = halt_req && !inflight_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural Memory_Text whose word at
// address a is 16'hA000 | a.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_we;
    logic [15:0] imem_data;
    logic [15:0] imem_q;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_we       (imem_we),
        .imem_data     (imem_data),
        .imem_q        (imem_q),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .halted        (halted),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory_Text: synchronous read, contents A000 | addr (aliases the whole space).
    always @(posedge clk) imem_q <= 16'hA000 | imem_addr;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        halt;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eaddr;
        logic        ehalted;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [15:0] rpc, input logic h, input logic ev,
                                input logic [15:0] epc, input logic [15:0] eaddr,
                                input logic eh);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.halt = h;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ehalted = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", nm, fld, act, exp);
        end
    endtask

    // Check outputs at the negedge of the current cycle, then advance past posedge.
    task automatic run_chk(input string nm, input logic ev, input logic [15:0] epc,
                           input logic [15:0] eaddr, input logic eh);
        logic [15:0] ein;
        ein = ev ? (16'hA000 | epc) : 16'h0000;
        @(negedge clk);
        chk(nm, "if_valid", {15'd0, if_valid}, {15'd0, ev});
        chk(nm, "if_pc", if_pc, ev ? epc : 16'h0000);
        chk(nm, "if_instr", if_instr, ein);
        chk(nm, "imem_addr", imem_addr, eaddr);
        chk(nm, "halted", {15'd0, halted}, {15'd0, eh});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input vec_t v, input string nm);
        rst            = v.rst;
        if_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        halt_req       = v.halt;
        run_chk(nm, v.ev, v.epc, v.eaddr, v.ehalted);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, boot cycle, streaming, backpressure, redirect, wrap-around.
        //             rst rdy rv rpc       h  ev epc       addr      halted
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0)); // S_BOOT
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0)); // issue 0
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0001, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 16'h0003, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 16'h0004, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0003, 16'h0005, 0));
        for (int k = 0; k < 5; k++)                                       // stall at 4
            vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0004, 16'h0006, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0004, 16'h0006, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0005, 16'h0007, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0006, 16'h0008, 0));
        vecs.push_back(mk(0, 1, 1, 16'h03F0, 0, 1, 16'h0007, 16'h03F0, 0)); // redirect
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h03F1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h03F0, 16'h03F2, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h03F1, 16'h03F3, 0));
        vecs.push_back(mk(0, 1, 1, 16'hFFFE, 0, 1, 16'h03F2, 16'hFFFE, 0)); // redirect
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'hFFFE, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'hFFFF, 16'h0001, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0002, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 16'h0003, 0));

        foreach (vecs[i]) cyc(vecs[i], $sformatf("vec%0d", i));

        // Halt mid-stream: head 2 shown now, word 3 still in flight, nothing new issued.
        halt_req = 1'b1; if_ready = 1'b1;
        run_chk("halt0", 1, 16'h0002, 16'h0004, 0);
        run_chk("halt1", 1, 16'h0003, 16'h0004, 1);
        run_chk("halt2", 0, 16'h0000, 16'h0004, 1);
        run_chk("halt3", 0, 16'h0000, 16'h0004, 1);
        // Release: one cycle in S_HALT, then issue resumes at pc 4.
        halt_req = 1'b0;
        run_chk("resume0", 0, 16'h0000, 16'h0004, 0);
        run_chk("resume1", 0, 16'h0000, 16'h0004, 0);
        run_chk("resume2", 0, 16'h0000, 16'h0005, 0);
        run_chk("resume3", 1, 16'h0004, 16'h0006, 0);

        // Fill the buffer under backpressure, then reset mid-operation.
        if_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            run_chk($sformatf("fill%0d", k), 1, 16'h0005, 16'h0007, 0);
        rst = 1'b1;
        run_chk("rst_pulse", 1, 16'h0005, 16'h0007, 0);
        // Boot cycle with a redirect that must be ignored.
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h1234;
        run_chk("reboot0", 0, 16'h0000, 16'h0000, 0);
        redirect_valid = 1'b0; if_ready = 1'b1;
        run_chk("reboot1", 0, 16'h0000, 16'h0000, 0);
        run_chk("reboot2", 0, 16'h0000, 16'h0001, 0);
        run_chk("reboot3", 1, 16'h0000, 16'h0002, 0);
        run_chk("reboot4", 1, 16'h0001, 16'h0003, 0);

        @(negedge clk);
        chk("tie", "imem_we", {15'd0, imem_we}, 16'h0000);
        chk("tie", "imem_data", imem_data, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
